// File: rtl/neg_unit_arbiter_pkg.sv
// Shared types and constants for the negation-unit arbiter: FSM states,
// opcodes and the default operand width.
package neg_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_NEG = 1'b0;
  localparam logic OP_ABS = 1'b1;

  localparam int DEFAULT_W = 16;
  localparam logic [DEFAULT_W-1:0] MOST_NEG = {1'b1, {(DEFAULT_W-1){1'b0}}};

endpackage : neg_unit_arbiter_pkg

// File: rtl/neg_unit_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the
// arbiter; the arbiter uses the slave view.
interface neg_unit_arbiter_if
  import neg_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = DEFAULT_W
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W-1:0]       rsp_data;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_ovf;

  modport master (
    output req_valid, req_data, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport slave (
    input  req_valid, req_data, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

endinterface : neg_unit_arbiter_if

// File: rtl/neg_unit_arbiter_twos_comp_unit.sv
// Combinational two's-complement negate / absolute-value unit with an
// overflow flag for the unrepresentable most-negative case.
module twos_comp_unit
  import neg_unit_arbiter_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] operand,
  input  logic         op,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam logic [W-1:0] MOST_NEG_W = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] negated;
  logic         do_neg;

  assign negated = ~operand + W'(1);
  // Abs only negates operands whose sign bit is set.
  assign do_neg  = (op == OP_NEG) || operand[W-1];
  assign result  = do_neg ? negated : operand;
  assign ovf     = do_neg && (operand == MOST_NEG_W);

endmodule : twos_comp_unit

// File: rtl/neg_unit_arbiter.sv
// Round-robin arbiter sharing one negation unit between N_REQ requesters:
// grant in IDLE, compute in CALC, hold the tagged result in RESP.
module neg_unit_arbiter
  import neg_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = DEFAULT_W
) (
  input logic              clk,
  input logic              rst_n,
  neg_unit_arbiter_if.slave bus
);

  localparam int              ID_W     = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   gnt_q;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              grant_found;
  logic [N_REQ-1:0]  ready;
  logic [W-1:0]      operand_q;
  logic              op_q;
  logic [W-1:0]      unit_result;
  logic              unit_ovf;
  logic [W-1:0]      rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              rsp_ovf_q;

  // Scan starts one past the last served index, so it has lowest priority.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    ready      = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          ready[grant_idx] = 1'b1;
          state_next       = CALC;
        end
      end
      CALC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  twos_comp_unit #(.W(W)) u_unit (
    .operand (operand_q),
    .op      (op_q),
    .result  (unit_result),
    .ovf     (unit_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q  <= '0;
      op_q       <= OP_NEG;
      gnt_q      <= '0;
      last_grant <= LAST_RST;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      if (state == IDLE && grant_found) begin
        operand_q <= bus.req_data[grant_idx*W +: W];
        op_q      <= bus.req_op[grant_idx];
        gnt_q     <= grant_idx;
      end
      // The pointer only advances once the operand is committed to the unit.
      if (state == CALC) begin
        rsp_data_q <= unit_result;
        rsp_ovf_q  <= unit_ovf;
        rsp_id_q   <= gnt_q;
        last_grant <= gnt_q;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ovf   = rsp_ovf_q;

endmodule : neg_unit_arbiter

// File: tb/tb_neg_unit_arbiter.sv
// Self-checking bench for neg_unit_arbiter: directed arithmetic corners plus
// randomized arbitration checked against a round-robin reference model.
module tb_neg_unit_arbiter;
  import neg_unit_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neg_unit_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  neg_unit_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int model_last   = N - 1;

  // Result model from plain integer arithmetic: {ovf, result}.
  function automatic logic [W:0] model_calc(input logic [W-1:0] x, input logic op);
    int unsigned v;
    int unsigned r;
    bit          neg;
    v   = x;
    neg = (op == OP_NEG) || (v >= 32768);
    r   = neg ? (65536 - v) % 65536 : v;
    return {(neg && v == 32768), 16'(r)};
  endfunction

  // First valid requester after 'last' in circular order, or -1.
  function automatic int rr_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== 16'h0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data); end
    tests_run++; if (bus.rsp_id !== 2'd0) begin tests_failed++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    tests_run++; if (bus.rsp_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_ovf: got %b expected 0", bus.rsp_ovf); end
  endtask

  // One transaction from a lone requester with rsp_ready held high.
  task automatic send_one(input int id, input logic [W-1:0] x, input logic op, input string name);
    logic [W:0]   exp;
    logic [N-1:0] exp_ready;
    exp       = model_calc(x, op);
    exp_ready = N'(1 << id);
    @(negedge clk);
    bus.req_valid             = exp_ready;
    bus.req_data[id*W +: W]   = x;
    bus.req_op[id]            = op;
    #1;
    tests_run++; if (bus.req_ready !== exp_ready) begin tests_failed++; $display("FAIL %s grant: got %b expected %b", name, bus.req_ready, exp_ready); end
    model_last = id;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL %s early_valid: got %b expected 0", name, bus.rsp_valid); end
    @(negedge clk);
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL %s latency: got rsp_valid %b expected 1", name, bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== exp[W-1:0]) begin tests_failed++; $display("FAIL %s data: got %h expected %h", name, bus.rsp_data, exp[W-1:0]); end
    tests_run++; if (bus.rsp_id !== 2'(id)) begin tests_failed++; $display("FAIL %s id: got %0d expected %0d", name, bus.rsp_id, id); end
    tests_run++; if (bus.rsp_ovf !== exp[W]) begin tests_failed++; $display("FAIL %s ovf: got %b expected %b", name, bus.rsp_ovf, exp[W]); end
  endtask

  task automatic test_single_negate();
    send_one(0, 16'h0005, OP_NEG, "single_neg");
  endtask

  task automatic test_abs_ovf();
    logic [W-1:0] x;
    send_one(1, 16'hFFF6, OP_ABS, "abs_neg");
    send_one(2, 16'h0007, OP_ABS, "abs_pos");
    send_one(3, MOST_NEG, OP_NEG, "neg_most_neg");
    send_one(0, 16'h0000, OP_NEG, "neg_zero");
    send_one(2, MOST_NEG, OP_ABS, "abs_most_neg");
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       x = MOST_NEG;
        1:       x = 16'h0000;
        2:       x = 16'h7FFF;
        3:       x = 16'hFFFF;
        default: x = 16'($urandom);
      endcase
      send_one(int'($urandom_range(0, N-1)), x, 1'($urandom_range(0, 1)), "rand_op");
    end
  endtask

  // All requesters busy first (strict 0,1,2,3,0,... order), then random masks.
  task automatic test_round_robin();
    logic [W:0]   exp_q[$];
    int           exp_id_q[$];
    logic [W:0]   exp;
    logic [N-1:0] exp_ready;
    int           since = 99;
    int           just  = -1;
    int           grants = 0;
    int           exp_g;
    int           exp_id;
    apply_reset();
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.req_valid = '1;
        bus.req_data  = {$urandom, $urandom};
        bus.req_op    = N'($urandom);
      end else if (c < 40) begin
        if (just >= 0) begin
          bus.req_data[just*W +: W] = 16'($urandom);
          bus.req_op[just]          = 1'($urandom);
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!bus.req_valid[i] || i == just) begin
            bus.req_valid[i]        = 1'($urandom_range(0, 1));
            bus.req_data[i*W +: W]  = 16'($urandom);
            bus.req_op[i]           = 1'($urandom);
          end
        end
      end
      just = -1;
      since++;
      #1;
      if (since < 3) exp_g = -1;
      else if (c < 40) exp_g = grants % N;
      else exp_g = rr_pick(bus.req_valid, model_last);
      exp_ready = (exp_g >= 0) ? N'(1 << exp_g) : '0;
      tests_run++; if (bus.req_ready !== exp_ready) begin tests_failed++; $display("FAIL rr_grant cycle %0d: got %b expected %b", c, bus.req_ready, exp_ready); end
      tests_run++; if (bus.rsp_valid !== (since == 2)) begin tests_failed++; $display("FAIL rr_rsp_valid cycle %0d: got %b expected %b", c, bus.rsp_valid, since == 2); end
      if (since == 2 && exp_q.size() > 0) begin
        exp    = exp_q.pop_front();
        exp_id = exp_id_q.pop_front();
        tests_run++; if ({bus.rsp_ovf, bus.rsp_data} !== exp) begin tests_failed++; $display("FAIL rr_data cycle %0d: got %b/%h expected %b/%h", c, bus.rsp_ovf, bus.rsp_data, exp[W], exp[W-1:0]); end
        tests_run++; if (bus.rsp_id !== 2'(exp_id)) begin tests_failed++; $display("FAIL rr_id cycle %0d: got %0d expected %0d", c, bus.rsp_id, exp_id); end
      end
      if (exp_g >= 0) begin
        exp_q.push_back(model_calc(bus.req_data[exp_g*W +: W], bus.req_op[exp_g]));
        exp_id_q.push_back(exp_g);
        model_last = exp_g;
        since      = 0;
        just       = exp_g;
        grants++;
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int           id;
    int           next_id;
    logic [W-1:0] x;
    logic         op;
    logic [W:0]   exp;
    logic [W:0]   exp2;
    id = int'($urandom_range(0, N-1));
    x  = 16'($urandom);
    op = 1'($urandom);
    exp = model_calc(x, op);
    @(negedge clk);
    bus.rsp_ready           = 1'b0;
    bus.req_valid           = N'(1 << id);
    bus.req_data[id*W +: W] = x;
    bus.req_op[id]          = op;
    #1;
    tests_run++; if (bus.req_ready !== N'(1 << id)) begin tests_failed++; $display("FAIL bp_grant: got %b expected %b", bus.req_ready, N'(1 << id)); end
    model_last = id;
    @(negedge clk);
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) if (i != id) bus.req_data[i*W +: W] = 16'($urandom);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      #1;
      tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold %0d: got %b expected 1", i, bus.rsp_valid); end
      tests_run++; if ({bus.rsp_ovf, bus.rsp_data} !== exp) begin tests_failed++; $display("FAIL bp_data_hold %0d: got %h expected %h", i, {bus.rsp_ovf, bus.rsp_data}, exp); end
      tests_run++; if (bus.rsp_id !== 2'(id)) begin tests_failed++; $display("FAIL bp_id_hold %0d: got %0d expected %0d", i, bus.rsp_id, id); end
      tests_run++; if (bus.req_ready !== 4'b0) begin tests_failed++; $display("FAIL bp_no_grant %0d: got %b expected 0000", i, bus.req_ready); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    next_id = rr_pick('1, model_last);
    exp2 = model_calc(bus.req_data[next_id*W +: W], bus.req_op[next_id]);
    @(negedge clk);
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release: got rsp_valid %b expected 0", bus.rsp_valid); end
    tests_run++; if (bus.req_ready !== N'(1 << next_id)) begin tests_failed++; $display("FAIL bp_next_grant: got %b expected %b", bus.req_ready, N'(1 << next_id)); end
    model_last = next_id;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    tests_run++; if ({bus.rsp_valid, bus.rsp_ovf, bus.rsp_data} !== {1'b1, exp2}) begin tests_failed++; $display("FAIL bp_next_rsp: got %b/%h expected 1/%h", bus.rsp_valid, {bus.rsp_ovf, bus.rsp_data}, exp2); end
    tests_run++; if (bus.rsp_id !== 2'(next_id)) begin tests_failed++; $display("FAIL bp_next_id: got %0d expected %0d", bus.rsp_id, next_id); end
  endtask

  task automatic test_reset_mid();
    send_one(1, 16'($urandom) | 16'h0001, OP_ABS, "pre_reset");
    @(negedge clk);
    bus.req_valid          = 4'b0100;
    bus.req_data[2*W +: W] = 16'h1234;
    bus.req_op[2]          = OP_NEG;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL mid_grant: got %b expected 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_valid: got %b expected 0", bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== 16'h0) begin tests_failed++; $display("FAIL mid_rst_data: got %h expected 0000", bus.rsp_data); end
    tests_run++; if (bus.rsp_id !== 2'd0) begin tests_failed++; $display("FAIL mid_rst_id: got %0d expected 0", bus.rsp_id); end
    tests_run++; if (bus.rsp_ovf !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ovf: got %b expected 0", bus.rsp_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_rsp %0d: got %b expected 0", i, bus.rsp_valid); end
    end
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    tests_run++; if (bus.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL mid_next_grant: got %b expected 0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_negate();
    test_abs_ovf();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_neg_unit_arbiter
